// File: rtl/perceptron_arbiter.sv
// Shares one perceptron between NREQ requesters: round-robin issue, in-order tag FIFO return.
// Define PERC_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module perceptron_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int TAG_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_val_i,
  output logic [NREQ-1:0]         req_rdy_o,
  input  logic [NREQ*WIDTH-1:0]   req_X0_i,
  input  logic [NREQ*WIDTH-1:0]   req_X1_i,
  output logic [NREQ-1:0]         resp_val_o,
  input  logic [NREQ-1:0]         resp_rdy_i,
  output logic                    resp_Y_o,
  output logic                    p_val_o,
  input  logic                    p_rdy_i,
  output logic [WIDTH-1:0]        p_X0_o,
  output logic [WIDTH-1:0]        p_X1_o,
  input  logic                    p_val_i,
  output logic                    p_rdy_o,
  input  logic                    p_Y_i
);
  localparam int IDW = $clog2(NREQ);
  localparam int PW  = $clog2(TAG_DEPTH);
  localparam int CW  = PW + 1;

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt;
  logic [IDW-1:0] idx;
  logic           any_req;
  logic           can_issue;
  logic           issue_fire;
  logic           ret_fire;
  logic           fifo_full;
  logic           fifo_empty;
  logic [IDW-1:0] head;
  logic [IDW-1:0] tag_mem [TAG_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    any_req = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(rr_ptr) + i) % NREQ);
      if (!any_req && req_val_i[idx]) begin
        gnt     = idx;
        any_req = 1'b1;
      end
    end
  end

  assign fifo_full  = (count == CW'(TAG_DEPTH));
  assign fifo_empty = (count == '0);
  assign head       = tag_mem[rd_ptr];

  // Full blocks issue even when a pop happens this cycle; no bypass path.
  assign can_issue  = !reset && any_req && !fifo_full;
  assign issue_fire = can_issue && p_rdy_i;
  assign p_val_o    = can_issue;
  assign p_X0_o     = can_issue ? req_X0_i[gnt*WIDTH +: WIDTH] : '0;
  assign p_X1_o     = can_issue ? req_X1_i[gnt*WIDTH +: WIDTH] : '0;

  always_comb begin
    req_rdy_o = '0;
    if (issue_fire) req_rdy_o[gnt] = 1'b1;
  end

  // A response with no tag outstanding is dropped: not accepted, not routed.
  assign p_rdy_o  = !reset && !fifo_empty && resp_rdy_i[head];
  assign ret_fire = p_val_i && p_rdy_o;
  assign resp_Y_o = p_Y_i;

  always_comb begin
    resp_val_o = '0;
    if (!reset && p_val_i && !fifo_empty) resp_val_o[head] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (issue_fire) wr_ptr <= wr_ptr + 1'b1;
      if (ret_fire)   rd_ptr <= rd_ptr + 1'b1;
      case ({issue_fire, ret_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (issue_fire) tag_mem[wr_ptr] <= gnt;
  end

`ifdef PERC_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge clk) begin
    if (reset)           rr_ptr <= '0;
    else if (issue_fire) rr_ptr <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_perceptron_arbiter.sv
// Directed bench for perceptron_arbiter (NREQ=4, WIDTH=8, TAG_DEPTH=4), both priority modes.
module tb_perceptron_arbiter;
  localparam bit FIXED =
`ifdef PERC_ARB_FIXED_PRIO_EN
    1'b1;
`else
    1'b0;
`endif
  localparam logic [31:0] XA0 = 32'h40302010, XA1 = 32'h44332211;
  localparam logic [31:0] XB0 = 32'h40052010, XB1 = 32'h44FD2211;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req_val_i = '0, req_rdy_o, resp_val_o, resp_rdy_i = '0;
  logic [31:0] req_X0_i = '0, req_X1_i = '0;
  logic resp_Y_o, p_val_o, p_rdy_i = 1'b0, p_val_i = 1'b0, p_rdy_o, p_Y_i = 1'b0;
  logic [7:0] p_X0_o, p_X1_o;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  perceptron_arbiter #(.NREQ(4), .WIDTH(8), .TAG_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .req_val_i(req_val_i), .req_rdy_o(req_rdy_o),
    .req_X0_i(req_X0_i), .req_X1_i(req_X1_i),
    .resp_val_o(resp_val_o), .resp_rdy_i(resp_rdy_i), .resp_Y_o(resp_Y_o),
    .p_val_o(p_val_o), .p_rdy_i(p_rdy_i), .p_X0_o(p_X0_o), .p_X1_o(p_X1_o),
    .p_val_i(p_val_i), .p_rdy_o(p_rdy_o), .p_Y_i(p_Y_i)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  rv;
    logic        prdy;
    logic        pv;
    logic        py;
    logic [3:0]  rr;
    logic [31:0] x0;
    logic [31:0] x1;
    logic [3:0]  e_rdy;
    logic        e_pval;
    logic [7:0]  e_x0;
    logic [7:0]  e_x1;
    logic        e_prdy;
    logic [3:0]  e_resp;
    logic        e_y;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [3:0] oh(input int k);
    logic [3:0] one;
    one = 4'b0001;
    return one << k;
  endfunction

  function automatic int g(input int k);
    return FIXED ? 0 : k;
  endfunction

  function automatic logic [7:0] sl(input logic [31:0] v, input int k);
    return v[k*8 +: 8];
  endfunction

  function automatic vec_t mk(input logic rst, input logic [3:0] rv, input logic prdy,
                              input logic pv, input logic py, input logic [3:0] rr,
                              input logic [31:0] x0, input logic [31:0] x1,
                              input logic [3:0] e_rdy, input logic e_pval,
                              input logic [7:0] e_x0, input logic [7:0] e_x1,
                              input logic e_prdy, input logic [3:0] e_resp, input logic e_y);
    vec_t v;
    v.rst = rst; v.rv = rv; v.prdy = prdy; v.pv = pv; v.py = py; v.rr = rr;
    v.x0 = x0; v.x1 = x1; v.e_rdy = e_rdy; v.e_pval = e_pval; v.e_x0 = e_x0;
    v.e_x1 = e_x1; v.e_prdy = e_prdy; v.e_resp = e_resp; v.e_y = e_y;
    return v;
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
  task automatic cyc(input logic rst, input logic [3:0] rv, input logic prdy, input logic pv,
                     input logic py, input logic [3:0] rr, input logic [31:0] x0,
                     input logic [31:0] x1);
    @(posedge clk);
    #1;
    reset = rst; req_val_i = rv; p_rdy_i = prdy; p_val_i = pv; p_Y_i = py;
    resp_rdy_i = rr; req_X0_i = x0; req_X1_i = x1;
    #3;
  endtask

  task automatic chk(input string name, input logic [3:0] e_rdy, input logic e_pval,
                     input logic [7:0] e_x0, input logic [7:0] e_x1, input logic e_prdy,
                     input logic [3:0] e_resp, input logic e_y);
    n_vec++;
    if (req_rdy_o !== e_rdy) begin
      n_bad++; $display("FAIL %s req_rdy_o got %b want %b", name, req_rdy_o, e_rdy);
    end
    if (p_val_o !== e_pval) begin
      n_bad++; $display("FAIL %s p_val_o got %b want %b", name, p_val_o, e_pval);
    end
    if (p_X0_o !== e_x0) begin
      n_bad++; $display("FAIL %s p_X0_o got %h want %h", name, p_X0_o, e_x0);
    end
    if (p_X1_o !== e_x1) begin
      n_bad++; $display("FAIL %s p_X1_o got %h want %h", name, p_X1_o, e_x1);
    end
    if (p_rdy_o !== e_prdy) begin
      n_bad++; $display("FAIL %s p_rdy_o got %b want %b", name, p_rdy_o, e_prdy);
    end
    if (resp_val_o !== e_resp) begin
      n_bad++; $display("FAIL %s resp_val_o got %b want %b", name, resp_val_o, e_resp);
    end
    if (resp_Y_o !== e_y) begin
      n_bad++; $display("FAIL %s resp_Y_o got %b want %b", name, resp_Y_o, e_y);
    end
  endtask

  initial begin
    int k;
    // Reset, round-robin sweep with concurrent returns, then routing of req2/req0.
    tbl[0]  = mk(1, 4'hF, 1, 0, 0, 4'hF, XA0, XA1, 4'h0, 0, 8'h00, 8'h00, 0, 4'h0, 0);
    tbl[1]  = tbl[0];
    tbl[2]  = mk(0, 4'hF, 1, 1, 0, 4'hF, XA0, XA1, oh(g(0)), 1, sl(XA0, g(0)), sl(XA1, g(0)),
                 0, 4'h0, 0);
    tbl[3]  = mk(0, 4'hF, 1, 1, 1, 4'hF, XA0, XA1, oh(g(1)), 1, sl(XA0, g(1)), sl(XA1, g(1)),
                 1, oh(0), 1);
    tbl[4]  = mk(0, 4'hF, 1, 1, 0, 4'hF, XA0, XA1, oh(g(2)), 1, sl(XA0, g(2)), sl(XA1, g(2)),
                 1, oh(g(1)), 0);
    tbl[5]  = mk(0, 4'hF, 1, 1, 1, 4'hF, XA0, XA1, oh(g(3)), 1, sl(XA0, g(3)), sl(XA1, g(3)),
                 1, oh(g(2)), 1);
    tbl[6]  = mk(0, 4'hF, 1, 1, 0, 4'hF, XA0, XA1, oh(0), 1, 8'h10, 8'h11, 1, oh(g(3)), 0);
    tbl[7]  = mk(0, 4'h0, 1, 1, 1, 4'hF, XA0, XA1, 4'h0, 0, 8'h00, 8'h00, 1, 4'b0001, 1);
    tbl[8]  = mk(0, 4'b0100, 1, 0, 0, 4'hF, XB0, XB1, 4'b0100, 1, 8'h05, 8'hFD, 0, 4'h0, 0);
    tbl[9]  = mk(0, 4'b0001, 1, 0, 0, 4'hF, XB0, XB1, 4'b0001, 1, 8'h10, 8'h11, 1, 4'h0, 0);
    tbl[10] = mk(0, 4'h0, 1, 1, 1, 4'hF, XB0, XB1, 4'h0, 0, 8'h00, 8'h00, 1, 4'b0100, 1);
    tbl[11] = mk(0, 4'h0, 1, 1, 0, 4'hF, XB0, XB1, 4'h0, 0, 8'h00, 8'h00, 1, 4'b0001, 0);

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].rst, tbl[i].rv, tbl[i].prdy, tbl[i].pv, tbl[i].py, tbl[i].rr,
          tbl[i].x0, tbl[i].x1);
      chk($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_pval, tbl[i].e_x0, tbl[i].e_x1,
          tbl[i].e_prdy, tbl[i].e_resp, tbl[i].e_y);
    end

    // Fill the tag FIFO (round-robin pointer starts at 1 here).
    for (int i = 0; i < 4; i++) begin
      k = g((i + 1) % 4);
      cyc(0, 4'hF, 1, 0, 0, 4'hF, XB0, XB1);
      chk("full_fill", oh(k), 1, sl(XB0, k), sl(XB1, k), i != 0, 4'h0, 0);
    end
    cyc(0, 4'hF, 1, 0, 0, 4'hF, XB0, XB1);
    chk("full_block", 4'h0, 0, 8'h00, 8'h00, 1, 4'h0, 0);
    cyc(0, 4'hF, 1, 1, 1, 4'hF, XB0, XB1);
    chk("full_pop_same", 4'h0, 0, 8'h00, 8'h00, 1, oh(g(1)), 1);
    k = g(1);
    cyc(0, 4'hF, 0, 0, 0, 4'hF, XB0, XB1);
    chk("full_resume", 4'h0, 1, sl(XB0, k), sl(XB1, k), 1, 4'h0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 4'h0, 0, 1, 0, 4'hF, XB0, XB1);
      chk("full_drain", 4'h0, 0, 8'h00, 8'h00, 1, oh(g((i + 2) % 4)), 0);
    end

    // Response backpressure on head tag 1.
    cyc(0, 4'b0010, 1, 0, 0, 4'hF, XB0, XB1);
    chk("bp_issue", 4'b0010, 1, 8'h20, 8'h22, 0, 4'h0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 4'h0, 1, 1, 1, 4'b1101, XB0, XB1);
      chk("bp_hold", 4'h0, 0, 8'h00, 8'h00, 0, 4'b0010, 1);
    end
    cyc(0, 4'h0, 1, 1, 1, 4'hF, XB0, XB1);
    chk("bp_pop", 4'h0, 0, 8'h00, 8'h00, 1, 4'b0010, 1);
    cyc(0, 4'h0, 1, 1, 1, 4'hF, XB0, XB1);
    chk("stray_resp", 4'h0, 0, 8'h00, 8'h00, 0, 4'h0, 1);

    // Issue stall on requester 3; pointer must hold at 2 until the fire.
    for (int i = 0; i < 3; i++) begin
      cyc(0, 4'b1000, 0, 0, 0, 4'hF, XB0, XB1);
      chk("stall", 4'h0, 1, 8'h40, 8'h44, 0, 4'h0, 0);
    end
    cyc(0, 4'b1001, 0, 0, 0, 4'hF, XB0, XB1);
    chk("stall_prio", 4'h0, 1, FIXED ? 8'h10 : 8'h40, FIXED ? 8'h11 : 8'h44, 0, 4'h0, 0);
    cyc(0, 4'b1000, 1, 0, 0, 4'hF, XB0, XB1);
    chk("stall_fire", 4'b1000, 1, 8'h40, 8'h44, 0, 4'h0, 0);
    cyc(0, 4'hF, 0, 0, 0, 4'hF, XB0, XB1);
    chk("rr_wrap", 4'h0, 1, 8'h10, 8'h11, 1, 4'h0, 0);

    // Reset with a tag in flight drops it.
    cyc(1, 4'hF, 1, 1, 0, 4'hF, XB0, XB1);
    chk("rst_mid", 4'h0, 0, 8'h00, 8'h00, 0, 4'h0, 0);
    cyc(0, 4'h0, 1, 1, 1, 4'hF, XB0, XB1);
    chk("rst_flush", 4'h0, 0, 8'h00, 8'h00, 0, 4'h0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
